// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: occupancy state encoding and the
// default bubble (NOP) instruction used by all inter-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle; master is the fetch/decode environment,
// slave is the skid register stage.
interface if_id_skid_reg_if #(
  parameter int PC_W  = 32,
  parameter int INS_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [INS_W-1:0] in_ins;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_ins;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_pc, in_ins, out_ready,
    input  in_ready, out_valid, out_pc, out_ins,
    input  occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_ins, out_ready,
    output in_ready, out_valid, out_pc, out_ins,
    output occupancy
  );

endinterface

// File: rtl/sat_counter.sv
// Width-parametrised saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID skid-buffer pipeline register with registered in_ready.
// Optional statistics counters are built when IF_ID_STATS_EN is defined.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int               PC_W       = 32,
  parameter int               INS_W      = 32,
  parameter logic [INS_W-1:0] BUBBLE_INS = INS_W'(NOP_INS),
  parameter int               CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
`ifdef IF_ID_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  if_id_skid_reg_if.slave   bus
);

  occ_e             state_q, state_d;
  logic             in_ready_q;
  logic [PC_W-1:0]  main_pc_q, skid_pc_q;
  logic [INS_W-1:0] main_ins_q, skid_ins_q;

  logic out_valid;
  logic in_xfer, out_xfer;
  logic ld_main_in, ld_skid_in, ld_main_skid;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = bus.in_valid & in_ready_q;
  assign out_xfer  = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_ONE;
      ST_ONE: begin
        if (out_xfer && !in_xfer) state_d = ST_EMPTY;
        if (in_xfer && !out_xfer) state_d = ST_TWO;
      end
      ST_TWO:   if (out_xfer) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Data only moves on transitions that carry an entry; flush blocks all.
  always_comb begin
    ld_main_in   = 1'b0;
    ld_skid_in   = 1'b0;
    ld_main_skid = 1'b0;
    if (!flush) begin
      unique case (1'b1)
        (state_q == ST_EMPTY): ld_main_in = in_xfer;
        (state_q == ST_ONE): begin
          ld_main_in = in_xfer & out_xfer;
          ld_skid_in = in_xfer & ~out_xfer;
        end
        (state_q == ST_TWO): ld_main_skid = out_xfer;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_pc_q  <= '0;
      main_ins_q <= BUBBLE_INS;
      skid_pc_q  <= '0;
      skid_ins_q <= BUBBLE_INS;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (ld_main_in) begin
        main_pc_q  <= bus.in_pc;
        main_ins_q <= bus.in_ins;
      end else if (ld_main_skid) begin
        main_pc_q  <= skid_pc_q;
        main_ins_q <= skid_ins_q;
      end
      if (ld_skid_in) begin
        skid_pc_q  <= bus.in_pc;
        skid_ins_q <= bus.in_ins;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = main_pc_q;
  assign bus.out_ins   = out_valid ? main_ins_q
                                   : BUBBLE_INS;
  assign bus.occupancy = state_q;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

`ifdef IF_ID_STATS_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (out_valid & ~bus.out_ready),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (flush),
    .cnt_o (flush_cnt)
  );
`endif

endmodule
